ndata_multicast_buffered: RTL and testbench
===========================================

// Module: ndata_multicast_buffered
// PURPOSE
// - Successor to the lock-step stream duplicator: fans one ndata stream out to NUM_OUTPUTS consumers.
// - Each output has its own DEPTH-entry FIFO, so a briefly stalled consumer does not throttle the others.
// - A per-packet destination mask selects which outputs receive each packet; a zero mask drops the packet.
// - Used where one stream feeds several operators with independent back-pressure.
// PARAMETERS
// - NUM_OUTPUTS  2   number of output streams, >=1
// - DEPTH        4   entries per output FIFO, power of two, >=2
// - CNT_WIDTH    32  width of the packet/drop counters, saturating
// PORTS
// - clk         in   1                    clock; all logic on rising edge
// - rst_n       in   1                    synchronous active-low reset
// - in          ndata_i.s  -              input stream #(data_t, NUM_ELEMENTS): data/keep/last/valid/ready
// - out         ndata_i.m  [NUM_OUTPUTS]  output streams, same parametrisation as in
// - cfg_mask    in   NUM_OUTPUTS          destination mask, sampled on the first beat of each packet
// - pkt_count   out  CNT_WIDTH            packets fully accepted with a non-zero mask
// - drop_count  out  CNT_WIDTH            packets accepted with a zero mask, i.e. discarded
// BEHAVIOUR
// - Reset: all FIFOs empty; out[i].valid=0; in_pkt=0; pkt_mask=0; pkt_count=0; drop_count=0.
// - Reset mid-packet flushes all buffered beats. The next accepted beat is treated as a packet start.
// - Active mask: act = in_pkt ? pkt_mask : cfg_mask.
// - in.ready = &(~act | ~full). This is combinational from FIFO state and cfg_mask only, never from in.valid.
// - A beat is accepted when in.valid && in.ready. It is written to FIFO i for every i with act[i]=1.
// - full[i] means count==DEPTH. There is no pass-through: a FIFO that is full this cycle blocks input even if out[i] pops.
// - Packet framing on an accepted beat:
//   - !in_pkt && !last: pkt_mask<=cfg_mask; in_pkt<=1.
//   - last: in_pkt<=0, then count the packet:
//     - act!=0: pkt_count++.
//     - act==0: drop_count++.
//   - A single-beat packet (first beat has last=1) uses cfg_mask directly and never sets in_pkt.
// - cfg_mask changes while in_pkt=1 are ignored until the packet ends. A packet is never split across masks.
// - FIFO outputs:
//   - out[i].valid = count[i]!=0.
//   - out[i].data/keep/last come from the FIFO head.
//   - Pop on out[i].valid && out[i].ready.
//   - Push and pop in the same cycle leave the count unchanged.
// - Latency: a beat accepted in cycle N is visible at out[i] in cycle N+1.
// - Throughput: one beat per cycle sustained while all masked consumers hold ready=1.
// - Output ordering: each output preserves input order. No ordering is defined between different outputs.
// - valid never depends on ready. Data is held stable while valid && !ready.
// - Counters saturate at all-ones and do not wrap.
// - Zero-mask beats are consumed at line rate (in.ready=1) and written nowhere.
// STRUCTURE
// - Shared stream package:
//   - ndata beat struct {data[NUM_ELEMENTS], keep, last} used as the FIFO word.
//   - a log2-based count-width helper.
// - Sub-module ndata_fifo_slice #(DEPTH): a single-clock register FIFO on ndata_i, instantiated NUM_OUTPUTS times.
//   - Interface: push, din, full, ndata_i.m out.
// - Top level holds only the mask/framing FSM (IDLE: in_pkt=0, IN_PKT: in_pkt=1), the ready reduction and the counters.
// TESTING
// - Broadcast: NUM_OUTPUTS=3, cfg_mask=3'b111, 8-beat packet, all ready=1
//   -> each output sees the same 8 beats at 1 cycle latency; last on beat 8; pkt_count=1.
// - Mask change mid-packet: cfg_mask=3'b101 at the first beat, switched to 3'b010 at beat 3
//   -> out0 and out2 get all beats, out1 gets none; the next packet goes to out1 only.
// - Decoupling: DEPTH=4, out1.ready=0, others ready=1, 6-beat packet to all
//   -> 4 beats accepted back-to-back, then in.ready=0 until out1 pops; out0/out2 drain to 4 beats meanwhile.
// - Drop: cfg_mask=0, 5-beat packet
//   -> in.ready=1 every cycle, no output valid, drop_count=1, pkt_count=0.
// - Reset mid-packet: rst_n=0 for 1 cycle after beat 2 of a 4-beat packet
//   -> all out valid=0 the next cycle, counters 0; the next beat latches a fresh cfg_mask.
// - Single-beat packets: 10 consecutive last=1 beats with alternating masks 01/10 (NUM_OUTPUTS=2)
//   -> 5 beats per output in order; pkt_count=10.

Source files
------------

// File: rtl/ndata_multicast_buffered_pkg.sv
// Shared stream types for the buffered multicast block: the FIFO word,
// the framing states and a helper that sizes occupancy counters.
package ndata_multicast_buffered_pkg;

  localparam int NDATA_ELEMENTS   = 4;
  localparam int NDATA_ELEM_WIDTH = 8;

  typedef logic [NDATA_ELEM_WIDTH-1:0] ndata_elem_t;

  typedef struct packed {
    ndata_elem_t [NDATA_ELEMENTS-1:0] data;
    logic [NDATA_ELEMENTS-1:0]        keep;
    logic                             last;
  } ndata_beat_t;

  typedef enum logic {
    IDLE,
    IN_PKT
  } frame_state_e;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ndata_i.sv
// ndata stream interface: a beat of NUM_ELEMENTS elements with keep/last,
// valid/ready handshake.
interface ndata_i #(
  parameter type data_t       = ndata_multicast_buffered_pkg::ndata_elem_t,
  parameter int  NUM_ELEMENTS = ndata_multicast_buffered_pkg::NDATA_ELEMENTS
);

  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);

endinterface

// File: rtl/ndata_multicast_buffered_fifo_slice.sv
// Single-clock register FIFO presenting its head on an ndata master port.
// Pushes arriving while full are ignored; the producer must gate on full.
module ndata_fifo_slice
  import ndata_multicast_buffered_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  ndata_beat_t din,
  output logic        full,
  ndata_i.m           out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  ndata_beat_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  logic             push_ok;
  logic             pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign push_ok   = push && !full;
  assign pop       = not_empty && out.ready;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out.valid = not_empty;
  assign out.data  = mem[rd_ptr].data;
  assign out.keep  = mem[rd_ptr].keep;
  assign out.last  = mem[rd_ptr].last;

endmodule

// File: rtl/ndata_multicast_buffered.sv
// Fans one ndata stream out to NUM_OUTPUTS independently buffered consumers,
// steering whole packets by a destination mask latched on the first beat.
module ndata_multicast_buffered
  import ndata_multicast_buffered_pkg::*;
#(
  parameter int NUM_OUTPUTS = 2,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ndata_i.s                      in,
  ndata_i.m                      out [NUM_OUTPUTS],
  input  logic [NUM_OUTPUTS-1:0] cfg_mask,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  frame_state_e           state;
  logic [NUM_OUTPUTS-1:0] pkt_mask;
  logic [NUM_OUTPUTS-1:0] act;
  logic [NUM_OUTPUTS-1:0] full;
  logic                   accept;
  ndata_beat_t            beat;

  // Ready only looks at the FIFOs this beat targets; unmasked outputs never stall input.
  assign act      = (state == IN_PKT) ? pkt_mask : cfg_mask;
  assign in.ready = &(~act | ~full);
  assign accept   = in.valid && in.ready;

  assign beat.data = in.data;
  assign beat.keep = in.keep;
  assign beat.last = in.last;

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
    ndata_fifo_slice #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept && act[i]),
      .din   (beat),
      .full  (full[i]),
      .out   (out[i])
    );
  end

  // A single-beat packet never leaves IDLE, so it always uses cfg_mask directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pkt_mask   <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in.last) begin
            state    <= IN_PKT;
            pkt_mask <= cfg_mask;
          end
        end
        IN_PKT: begin
          if (in.last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (in.last) begin
        if (act != '0) begin
          if (pkt_count != '1) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
          end
        end else if (drop_count != '1) begin
          drop_count <= drop_count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ndata_multicast_buffered.sv
// Directed plus randomized bench for ndata_multicast_buffered, checked each
// cycle against a queue-per-output reference model.
module tb_ndata_multicast_buffered;
  import ndata_multicast_buffered_pkg::*;

  localparam int NO    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NO-1:0] cfg_mask = '0;
  logic [NO-1:0] rdy = '0;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] drop_count;

  ndata_i in_if ();
  ndata_i out_if [NO] ();

  logic [NO-1:0] o_valid;
  ndata_beat_t   o_beat [NO];

  for (genvar g = 0; g < NO; g++) begin : g_tap
    assign o_valid[g]      = out_if[g].valid;
    assign o_beat[g]       = {out_if[g].data, out_if[g].keep, out_if[g].last};
    assign out_if[g].ready = rdy[g];
  end

  ndata_multicast_buffered #(
    .NUM_OUTPUTS (NO),
    .DEPTH       (DEPTH),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_if),
    .out        (out_if),
    .cfg_mask   (cfg_mask),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: what each output should be holding, plus packet framing.
  ndata_beat_t   mq [NO][$];
  logic          m_in_pkt = 1'b0;
  logic [NO-1:0] m_mask = '0;
  int            m_pkt = 0;
  int            m_drop = 0;
  int            ready_mode [NO];
  logic          last_acc = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [NO-1:0] act;
    logic [NO-1:0] pop;
    logic          exp_rdy;
    logic          acc;
    ndata_beat_t   b;
    for (int i = 0; i < NO; i++) begin
      rdy[i] = (ready_mode[i] == 2) ? 1'($urandom_range(0, 1)) : (ready_mode[i] == 1);
    end
    @(negedge clk);
    act     = m_in_pkt ? m_mask : cfg_mask;
    exp_rdy = 1'b1;
    for (int i = 0; i < NO; i++) begin
      if (act[i] && mq[i].size() >= DEPTH) exp_rdy = 1'b0;
    end
    chk("in_ready", in_if.ready, exp_rdy);
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("out%0d_valid", i), o_valid[i], mq[i].size() != 0);
      if (mq[i].size() != 0) chk($sformatf("out%0d_beat", i), o_beat[i], mq[i][0]);
      pop[i] = (mq[i].size() != 0) && rdy[i];
    end
    chk("pkt_count", pkt_count, m_pkt);
    chk("drop_count", drop_count, m_drop);
    acc = in_if.valid && exp_rdy;
    b   = {in_if.data, in_if.keep, in_if.last};
    @(posedge clk);
    last_acc = acc && rst_n;
    if (!rst_n) begin
      for (int i = 0; i < NO; i++) mq[i].delete();
      m_in_pkt = 1'b0;
      m_mask   = '0;
      m_pkt    = 0;
      m_drop   = 0;
    end else begin
      for (int i = 0; i < NO; i++) begin
        if (pop[i]) void'(mq[i].pop_front());
      end
      if (acc) begin
        for (int i = 0; i < NO; i++) begin
          if (act[i]) mq[i].push_back(b);
        end
        if (b.last) begin
          m_in_pkt = 1'b0;
          if (act != '0) m_pkt = (m_pkt < CMAX) ? m_pkt + 1 : CMAX;
          else m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
        end else if (!m_in_pkt) begin
          m_in_pkt = 1'b1;
          m_mask   = cfg_mask;
        end
      end
    end
    #1;
  endtask

  task automatic send_beat(input logic last, output int tries);
    in_if.valid = 1'b1;
    in_if.data  = $urandom;
    in_if.keep  = 4'($urandom);
    in_if.last  = last;
    tries = 0;
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 64);
    vectors++;
    assert (last_acc) else begin
      miscompares++;
      $error("[TB] FAIL accept_timeout observed=%0d expected=1", last_acc);
    end
    in_if.valid = 1'b0;
  endtask

  task automatic send_packet(input int len, input logic [NO-1:0] mask,
                             input int sw_beat, input logic [NO-1:0] sw_mask);
    int t;
    cfg_mask = mask;
    for (int b = 1; b <= len; b++) begin
      if (b == sw_beat) cfg_mask = sw_mask;
      send_beat(b == len, t);
    end
  endtask

  task automatic drain();
    int n = 0;
    for (int i = 0; i < NO; i++) ready_mode[i] = 1;
    in_if.valid = 1'b0;
    while ((mq[0].size() + mq[1].size() + mq[2].size()) != 0 && n < 64) begin
      cycle();
      n++;
    end
    cycle();
  endtask

  initial begin
    int t;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.keep  = '0;
    in_if.last  = 1'b0;
    for (int i = 0; i < NO; i++) ready_mode[i] = 1;

    // Reset state.
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Broadcast 8-beat packet at full rate.
    cfg_mask = 3'b111;
    for (int b = 1; b <= 8; b++) begin
      send_beat(b == 8, t);
      chk("bcast_tries", t, 1);
    end
    drain();

    // Mid-packet mask change is ignored; the following packet uses the new mask.
    send_packet(4, 3'b101, 3, 3'b010);
    send_packet(3, 3'b010, 0, 3'b000);
    drain();

    // Decoupling: out1 stalled, six-beat packet to all.
    ready_mode[1] = 0;
    cfg_mask = 3'b111;
    for (int b = 1; b <= 4; b++) begin
      send_beat(1'b0, t);
      chk("decouple_tries", t, 1);
    end
    in_if.valid = 1'b1;
    in_if.last  = 1'b0;
    repeat (3) cycle();
    ready_mode[1] = 1;
    send_beat(1'b0, t);
    send_beat(1'b1, t);
    drain();

    // Zero mask drops at line rate.
    cfg_mask = 3'b000;
    for (int b = 1; b <= 5; b++) begin
      send_beat(b == 5, t);
      chk("drop_tries", t, 1);
    end
    drain();

    // Reset mid-packet, then a fresh packet latches the new mask.
    cfg_mask = 3'b011;
    send_beat(1'b0, t);
    send_beat(1'b0, t);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    send_packet(2, 3'b100, 0, 3'b000);
    drain();

    // Single-beat packets with alternating masks under random back-pressure.
    for (int i = 0; i < NO; i++) ready_mode[i] = 2;
    for (int k = 0; k < 10; k++) begin
      cfg_mask = k[0] ? 3'b010 : 3'b001;
      send_beat(1'b1, t);
    end
    drain();

    // Random packets and masks; pushes both counters into saturation.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NO; i++) ready_mode[i] = 2;
      send_packet($urandom_range(1, 6), 3'($urandom_range(1, 7)),
                  $urandom_range(0, 6), 3'($urandom));
    end
    for (int k = 0; k < 20; k++) begin
      send_packet($urandom_range(1, 3), 3'b000, 0, 3'b000);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
